// File: rtl/dds_sweep_ctrl.sv
// Stepped-frequency sweep sequencer: drives ICB writes into the DDS register
// file (FCW to con0, enable to con1) and dwells a fixed number of cycles per step.
module dds_sweep_ctrl #(
  parameter logic [7:0] ADR_CON0 = 8'd0,
  parameter logic [7:0] ADR_CON1 = 8'd1
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] cfg_fcw_start,
  input  logic [31:0] cfg_fcw_step,
  input  logic [15:0] cfg_nsteps,
  input  logic [15:0] cfg_dwell,
  output logic        m_icb_wr,
  output logic [7:0]  m_icb_wadr,
  output logic [31:0] m_icb_wdat,
  input  logic        m_icb_wack,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [31:0] cur_fcw,
  output logic [15:0] step_idx
);

  typedef enum logic [2:0] {
    IDLE, WR_F, WR_EN, DWELL, WR_DIS, FIN
  } state_t;

  state_t      state, state_n;
  logic [31:0] fcw;
  logic [31:0] fcw_step;
  logic [15:0] nsteps;
  logic [15:0] dwell_ld;
  logic [15:0] dcnt;
  logic        abort_flag;
  logic        abort_any;
  logic        dwell_last;
  logic [15:0] step_next;

  assign abort_any  = abort_flag | abort;
  assign dwell_last = (dcnt == 16'd1);
  assign step_next  = step_idx + 16'd1;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (start) state_n = (cfg_nsteps == 16'd0) ? FIN : WR_F;
      WR_F:   if (m_icb_wack) begin
                if (abort_any)               state_n = WR_DIS;
                else if (step_idx == 16'd0)  state_n = WR_EN;
                else                         state_n = DWELL;
              end
      WR_EN:  if (m_icb_wack) state_n = abort_any ? WR_DIS : DWELL;
      DWELL:  if (abort_any)       state_n = WR_DIS;
              else if (dwell_last) state_n = (step_next == nsteps) ? WR_DIS : WR_F;
      WR_DIS: if (m_icb_wack) state_n = FIN;
      FIN:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state      <= IDLE;
      fcw        <= '0;
      fcw_step   <= '0;
      nsteps     <= '0;
      dwell_ld   <= '0;
      dcnt       <= '0;
      abort_flag <= 1'b0;
      cur_fcw    <= '0;
      step_idx   <= '0;
    end else begin
      state <= state_n;

      if (state == IDLE && start) begin
        fcw_step <= cfg_fcw_step;
        nsteps   <= cfg_nsteps;
        dwell_ld <= (cfg_dwell == 16'd0) ? 16'd1 : cfg_dwell;
        if (cfg_nsteps != 16'd0) begin
          fcw      <= cfg_fcw_start;
          step_idx <= '0;
        end
      end

      if (state == IDLE || state == FIN) abort_flag <= 1'b0;
      else if (abort)                    abort_flag <= 1'b1;

      if (state == WR_F && m_icb_wack) cur_fcw <= fcw;

      // Counter is loaded on the edge entering DWELL so the first dwell cycle sees the full count.
      if (state_n == DWELL && state != DWELL) dcnt <= dwell_ld;
      else if (state == DWELL)                dcnt <= dcnt - 16'd1;

      if (state == DWELL && !abort_any && dwell_last) begin
        step_idx <= step_next;
        if (step_next != nsteps) fcw <= fcw + fcw_step;
      end
    end
  end

  // Bus and status outputs decode only the state register, so they change solely at clock edges.
  always_comb begin
    m_icb_wr   = 1'b0;
    m_icb_wadr = '0;
    m_icb_wdat = '0;
    unique case (state)
      WR_F:   begin m_icb_wr = 1'b1; m_icb_wadr = ADR_CON0; m_icb_wdat = fcw;   end
      WR_EN:  begin m_icb_wr = 1'b1; m_icb_wadr = ADR_CON1; m_icb_wdat = 32'h1; end
      WR_DIS: begin m_icb_wr = 1'b1; m_icb_wadr = ADR_CON1; m_icb_wdat = 32'h0; end
      default: ;
    endcase
  end

  assign busy    = (state != IDLE) && (state != FIN);
  assign done    = (state == FIN) && !abort_flag;
  assign aborted = (state == FIN) && abort_flag;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: records ICB writes and status pulses by
// cycle relative to the start pulse and compares against hand-derived schedules.
module tb_dds_sweep_ctrl;

  logic        clk;
  logic        rst_;
  logic        start;
  logic        abort;
  logic [31:0] cfg_fcw_start;
  logic [31:0] cfg_fcw_step;
  logic [15:0] cfg_nsteps;
  logic [15:0] cfg_dwell;
  logic        wr;
  logic [7:0]  wadr;
  logic [31:0] wdat;
  logic        wack;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [31:0] cur_fcw;
  logic [15:0] step_idx;

  int nvec = 0;
  int nerr = 0;

  dds_sweep_ctrl #(.ADR_CON0(8'd0), .ADR_CON1(8'd1)) dut (
    .clk(clk), .rst_(rst_), .start(start), .abort(abort),
    .cfg_fcw_start(cfg_fcw_start), .cfg_fcw_step(cfg_fcw_step),
    .cfg_nsteps(cfg_nsteps), .cfg_dwell(cfg_dwell),
    .m_icb_wr(wr), .m_icb_wadr(wadr), .m_icb_wdat(wdat), .m_icb_wack(wack),
    .busy(busy), .done(done), .aborted(aborted),
    .cur_fcw(cur_fcw), .step_idx(step_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ICB responder: ack after 'delay' wait cycles; 'spurious' holds wack high even when idle.
  int delay = 0;
  int rcnt  = 0;
  bit spurious = 1'b0;
  assign wack = (wr && (rcnt >= delay)) || spurious;
  always @(posedge clk) begin
    if (!wr || wack) rcnt <= 0;
    else             rcnt <= rcnt + 1;
  end

  logic [7:0]  w_adr [16];
  logic [31:0] w_dat [16];
  int          w_cyc [16];
  int nw, wr_cycles, busy_cycles, done_cnt, done_cyc, ab_cnt, ab_cyc;
  logic done_busy;
  int t0 = 0;
  bit logging = 1'b0;

  always @(negedge clk) begin
    if (logging) begin
      if (wr)   wr_cycles++;
      if (busy) busy_cycles++;
      if (wr && wack && nw < 16) begin
        w_adr[nw] = wadr;
        w_dat[nw] = wdat;
        w_cyc[nw] = cyc - t0;
        nw++;
      end
      if (done)    begin done_cnt++; done_cyc = cyc - t0; done_busy = busy; end
      if (aborted) begin ab_cnt++;   ab_cyc   = cyc - t0; end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input int i, input logic [7:0] a, input logic [31:0] d, input int c);
    chk($sformatf("wr%0d_adr", i), {56'd0, w_adr[i]}, {56'd0, a});
    chk($sformatf("wr%0d_dat", i), {32'd0, w_dat[i]}, {32'd0, d});
    chk($sformatf("wr%0d_cyc", i), 64'(w_cyc[i]), 64'(c));
  endtask

  task automatic clear_log();
    for (int unsigned i = 0; i < 16; i++) begin
      w_adr[i] = '1; w_dat[i] = '1; w_cyc[i] = -1;
    end
    nw = 0; wr_cycles = 0; busy_cycles = 0;
    done_cnt = 0; done_cyc = -1; ab_cnt = 0; ab_cyc = -1; done_busy = 1'bx;
  endtask

  task automatic run(input logic [31:0] fs, input logic [31:0] fst, input logic [15:0] n,
                     input logic [15:0] d, input int dly, input bit spur, input bit ab_with_start);
    cfg_fcw_start = fs; cfg_fcw_step = fst; cfg_nsteps = n; cfg_dwell = d;
    delay = dly; spurious = spur;
    clear_log();
    logging = 1'b1;
    @(negedge clk);
    t0 = cyc; start = 1'b1; abort = ab_with_start;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_rel(input int c);
    while (cyc - t0 < c) @(negedge clk);
  endtask

  task automatic wait_end(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (done_cnt + ab_cnt > 0) break;
      @(negedge clk);
    end
    chk("end_seen", 64'(done_cnt + ab_cnt > 0), 64'd1);
    repeat (3) @(negedge clk);
    logging = 1'b0; spurious = 1'b0;
  endtask

  initial begin
    rst_ = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_fcw_start = '0; cfg_fcw_step = '0; cfg_nsteps = '0; cfg_dwell = '0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {wr, wadr, wdat, busy, done, aborted}, 64'd0);
    rst_ = 1'b1;
    @(negedge clk);
    chk("rst_wr_bus", {wr, wadr, wdat}, 64'd0);
    chk("rst_status", {busy, done, aborted}, 64'd0);
    chk("rst_cur_fcw", {32'd0, cur_fcw}, 64'd0);
    chk("rst_step_idx", {48'd0, step_idx}, 64'd0);

    // Reference sweep, zero-wait ack, wack also high while idle, cfg changed after start
    run(32'h0040_0000, 32'h0010_0000, 16'd3, 16'd4, 0, 1'b1, 1'b0);
    cfg_fcw_start = 32'hDEAD_BEEF; cfg_fcw_step = 32'h1; cfg_nsteps = 16'd1; cfg_dwell = 16'd9;
    wait_end(100);
    chk("a_nw", 64'(nw), 64'd5);
    chk_wr(0, 8'd0, 32'h0040_0000, 1);
    chk_wr(1, 8'd1, 32'h1, 2);
    chk_wr(2, 8'd0, 32'h0050_0000, 7);
    chk_wr(3, 8'd0, 32'h0060_0000, 12);
    chk_wr(4, 8'd1, 32'h0, 17);
    chk("a_done_cyc", 64'(done_cyc), 64'd18);
    chk("a_done_cnt", 64'(done_cnt), 64'd1);
    chk("a_busy_at_done", {63'd0, done_busy}, 64'd0);
    chk("a_busy_cycles", 64'(busy_cycles), 64'd17);
    chk("a_ab_cnt", 64'(ab_cnt), 64'd0);
    chk("a_step_idx", {48'd0, step_idx}, 64'd3);
    chk("a_cur_fcw", {32'd0, cur_fcw}, 64'h0060_0000);

    // Same sweep with two wait cycles on every write
    run(32'h0040_0000, 32'h0010_0000, 16'd3, 16'd4, 2, 1'b0, 1'b0);
    wait_end(100);
    chk("b_nw", 64'(nw), 64'd5);
    chk_wr(0, 8'd0, 32'h0040_0000, 3);
    chk_wr(1, 8'd1, 32'h1, 6);
    chk_wr(2, 8'd0, 32'h0050_0000, 13);
    chk_wr(3, 8'd0, 32'h0060_0000, 20);
    chk_wr(4, 8'd1, 32'h0, 27);
    chk("b_wr_cycles", 64'(wr_cycles), 64'd15);
    chk("b_done_cyc", 64'(done_cyc), 64'd28);
    chk("b_step_idx", {48'd0, step_idx}, 64'd3);

    // Zero steps: done only, no bus traffic even with wack held high
    run(32'h1234_5678, 32'h1, 16'd0, 16'd4, 0, 1'b1, 1'b0);
    wait_end(20);
    chk("c_nw", 64'(nw), 64'd0);
    chk("c_wr_cycles", 64'(wr_cycles), 64'd0);
    chk("c_busy_cycles", 64'(busy_cycles), 64'd0);
    chk("c_done_cyc", 64'(done_cyc), 64'd1);
    chk("c_step_idx", {48'd0, step_idx}, 64'd3);

    // Dwell 0 acts as 1; abort coincident with start in IDLE is ignored
    run(32'h0000_1000, 32'h0000_0010, 16'd2, 16'd0, 0, 1'b0, 1'b1);
    wait_end(50);
    chk("d_nw", 64'(nw), 64'd4);
    chk_wr(0, 8'd0, 32'h0000_1000, 1);
    chk_wr(1, 8'd1, 32'h1, 2);
    chk_wr(2, 8'd0, 32'h0000_1010, 4);
    chk_wr(3, 8'd1, 32'h0, 6);
    chk("d_done_cyc", 64'(done_cyc), 64'd7);
    chk("d_ab_cnt", 64'(ab_cnt), 64'd0);

    // Abort in the second dwell (cycles 8..11)
    run(32'h0040_0000, 32'h0010_0000, 16'd3, 16'd4, 0, 1'b0, 1'b0);
    wait_rel(9);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_end(50);
    chk("e_nw", 64'(nw), 64'd4);
    chk_wr(2, 8'd0, 32'h0050_0000, 7);
    chk_wr(3, 8'd1, 32'h0, 10);
    chk("e_ab_cyc", 64'(ab_cyc), 64'd11);
    chk("e_ab_cnt", 64'(ab_cnt), 64'd1);
    chk("e_done_cnt", 64'(done_cnt), 64'd0);
    chk("e_step_idx", {48'd0, step_idx}, 64'd1);
    chk("e_cur_fcw", {32'd0, cur_fcw}, 64'h0050_0000);

    // FCW wrap; start pulses while busy (with new cfg) must not disturb the sweep
    run(32'hFFF0_0000, 32'h0020_0000, 16'd2, 16'd2, 0, 1'b0, 1'b0);
    cfg_fcw_start = 32'h0000_AAAA; cfg_fcw_step = 32'h5; cfg_nsteps = 16'd7; cfg_dwell = 16'd1;
    wait_rel(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_rel(6);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end(50);
    chk("f_nw", 64'(nw), 64'd4);
    chk_wr(0, 8'd0, 32'hFFF0_0000, 1);
    chk_wr(1, 8'd1, 32'h1, 2);
    chk_wr(2, 8'd0, 32'h0010_0000, 5);
    chk_wr(3, 8'd1, 32'h0, 8);
    chk("f_done_cyc", 64'(done_cyc), 64'd9);
    chk("f_done_cnt", 64'(done_cnt), 64'd1);
    chk("f_step_idx", {48'd0, step_idx}, 64'd2);

    // Reset mid-sweep clears everything immediately
    run(32'h0040_0000, 32'h0010_0000, 16'd3, 16'd4, 0, 1'b0, 1'b0);
    wait_rel(8);
    rst_ = 1'b0;
    #1;
    chk("g_rst_bus", {wr, wadr, wdat}, 64'd0);
    chk("g_rst_status", {busy, done, aborted}, 64'd0);
    chk("g_rst_regs", {cur_fcw, 16'd0, step_idx}, 64'd0);
    @(negedge clk);
    rst_ = 1'b1;
    logging = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep sequencer for the DDS core. It acts as an ICB write master in front of the `dds_wcfg` register file. On a start pulse it writes a stepped frequency control word to `con0` (addr 0) and enables output via `con1` (addr 1). It then dwells a programmable number of cycles per step and disables the DDS after the last step. This replaces manual per-step register writes when the DDS is driven as a stepped chirp or frequency scanner.

## Interface
Parameters:
- `ADR_CON0`, default 8'd0: ICB address of the frequency control word register.
- `ADR_CON1`, default 8'd1: ICB address of the enable register (bit0 = enable).

Ports:
- `clk`  in  1  clock.
- `rst_`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse that launches a sweep. Ignored while `busy`.
- `abort`  in  1  one-cycle pulse that terminates the sweep early.
- `cfg_fcw_start`  in  32  frequency control word (FCW) for step 0.
- `cfg_fcw_step`  in  32  FCW increment per step, added modulo 2^32.
- `cfg_nsteps`  in  16  number of steps. 0 = no sweep.
- `cfg_dwell`  in  16  cycles to dwell per step. 0 is treated as 1.
- `m_icb_wr`  out  1  write request, held until acknowledged.
- `m_icb_wadr`  out  8  write address.
- `m_icb_wdat`  out  32  write data.
- `m_icb_wack`  in  1  write acknowledge.
- `busy`  out  1  high from the cycle after `start` until the cycle of `done`/`aborted`.
- `done`  out  1  one-cycle pulse when a sweep completes normally.
- `aborted`  out  1  one-cycle pulse when an abort completes.
- `cur_fcw`  out  32  last FCW written to `con0`.
- `step_idx`  out  16  number of completed dwells.

## Operation
- States: IDLE, WR_F, WR_EN, DWELL, WR_DIS, FIN.
- All `cfg_*` inputs are latched on the `start` edge. Later changes have no effect on a running sweep.
- **IDLE:**
  - `start` with latched nsteps = 0 goes to FIN. This pulses `done` with no ICB traffic.
  - Otherwise load fcw = `cfg_fcw_start`, clear `step_idx`, and go to WR_F.
- **WR_F:** drive wr=1, adr=ADR_CON0, dat=fcw. When wr&&wack, update `cur_fcw`. Go to WR_EN if `step_idx`==0, else go to DWELL.
- **WR_EN:** write 32'h1 to ADR_CON1, then go to DWELL.
- **DWELL:**
  - The down-counter loads max(dwell,1) on entry and stays in DWELL for exactly that many cycles.
  - On the last cycle, `step_idx`++.
  - If the new `step_idx`==nsteps, go to WR_DIS. Otherwise fcw += step and go to WR_F.
- **WR_DIS:** write 32'h0 to ADR_CON1, then go to FIN.
- **FIN:** one cycle. Pulse `done`, or `aborted` if the abort flag is set. `busy`=0. Clear the flag and return to IDLE.
- **ICB handshake:**
  - `m_icb_wr` is registered. `wadr`/`wdat` are stable while wr=1.
  - A transfer completes on the edge where wr&&wack. wr drops the following cycle.
  - `wack` may be high in the same cycle wr rises (zero-wait). Otherwise it can arrive any number of cycles later. No timeout.
  - `wack` while wr=0 is ignored.
- **Abort:**
  - Sets a sticky flag in any non-IDLE state.
  - An in-flight ICB write is completed first. DWELL exits immediately. The next state is WR_DIS, and FIN then pulses `aborted`.
  - In IDLE, `abort` has no effect. If `start` and `abort` arrive in the same IDLE cycle, `abort` is ignored and the sweep starts.
  - `abort` during WR_DIS or FIN only sets the flag, or is moot.
- FCW overflow wraps silently. `step_idx` never exceeds nsteps.
- Reset mid-sweep: all state is cleared at once and no disable write is issued. Software must re-program the DDS if required.

## Timing
- Reset values: `m_icb_wr`=0, `m_icb_wadr`=0, `m_icb_wdat`=0, `busy`=0, `done`=0, `aborted`=0, `cur_fcw`=0, `step_idx`=0. State is IDLE.
- `start` is sampled at cycle 0. The first wr is high in cycle 1.
- With zero-wait ack and N steps of dwell D:
  - con0 write in c1, con1=1 in c2.
  - Each step is D dwell cycles. Each later step is preceded by a 1-cycle con0 write.
  - con1=0 in cycle N·(D+1)+2. `done` in cycle N·(D+1)+3.
- Each wait cycle on `wack` adds exactly one cycle to the schedule.

## Test plan
- start=1<<22, step=1<<20, N=3, D=4, zero-wait ack -> writes:
  - (0,0x400000)@c1, (1,1)@c2, (0,0x500000)@c7, (0,0x600000)@c12, (1,0)@c17.
  - `done`@c18, `busy` low @c18, `step_idx`=3.
- Same configuration with `wack` delayed 2 cycles on every write -> same write sequence. wr is held 3 cycles each. `done` is delayed by 10 cycles (c28).
- N=0 -> no `m_icb_wr` activity, `done` pulse at c1.
- D=0, N=2 -> behaves as D=1. con0 writes at c1 and c4, con1=0 at c6, `done`@c7.
- `abort` during the second dwell -> (1,0) write on the next cycle, `aborted` pulse, no `done`, `step_idx`=1.
- Wrap case: start=32'hFFF0_0000, step=32'h0020_0000, N=2 -> second con0 data is 32'h0010_0000. `start` while `busy` is ignored: no restart, and the latched config is unchanged.
